// File: rtl/wb_pkg.sv
// wb_pkg: shared definitions for the write-back stage.
//   - ld_size_e   : load-size encodings (byte, half, word32, full width)
//   - RST_*       : W-register field reset/bubble values
//   - inst_sz_ok  : legal datapath widths (32 or 64)
package wb_pkg;

    typedef enum logic [1:0] {
        LD_BYTE = 2'b00,
        LD_HALF = 2'b01,
        LD_WORD = 2'b10,
        LD_FULL = 2'b11
    } ld_size_e;

    // Bubble/reset contents of the W register; data fields are
    // replicated from RST_DATA_BIT to the parameterised width.
    localparam logic     RST_VALID     = 1'b0;
    localparam logic     RST_CTRL      = 1'b0;
    localparam logic     RST_DATA_BIT  = 1'b0;
    localparam ld_size_e RST_LOAD_SIZE = LD_BYTE;

    // Only 32- and 64-bit datapaths have a defined word32/full alignment.
    function automatic bit inst_sz_ok(input int unsigned w);
        return (w == 32'd32) || (w == 32'd64);
    endfunction

endpackage

// File: rtl/wb_pipe_load_align.sv
// wb_pipe_load_align: combinational sub-word load alignment and extension.
// Ports:
//   i_data     raw little-endian data-memory word
//   i_off      byte offset within the word
//   i_size     access size (ld_size_e)
//   i_unsigned 1 = zero-extend, 0 = sign-extend from the field's top bit
//   o_data     aligned, extended result
// Misaligned halves/words are truncated down to their natural boundary.
module wb_pipe_load_align
    import wb_pkg::*;
#(
    parameter int INST_SZ = 32,
    parameter int OFF_SZ  = $clog2(INST_SZ / 8)
) (
    input  logic [INST_SZ-1:0] i_data,
    input  logic [OFF_SZ-1:0]  i_off,
    input  ld_size_e           i_size,
    input  logic               i_unsigned,
    output logic [INST_SZ-1:0] o_data
);

    // Offsets with the ignored low bits cleared for half/word accesses.
    localparam logic [OFF_SZ-1:0] HALF_MASK = ~(OFF_SZ'(1));
    localparam logic [OFF_SZ-1:0] WORD_MASK = ~(OFF_SZ'(3));

    logic [OFF_SZ+2:0]  w_shamt;
    logic [INST_SZ-1:0] w_shifted;
    logic [INST_SZ-1:0] w_field_mask;
    logic               w_sign;

    // Shift the addressed field down to bit 0 and pick its mask and sign bit.
    always_comb begin
        w_shamt      = {OFF_SZ + 3{1'b0}};
        w_field_mask = {INST_SZ{1'b1}};
        case (i_size)
            LD_BYTE: begin
                w_shamt      = {i_off, 3'b000};
                w_field_mask = INST_SZ'(8'hFF);
            end
            LD_HALF: begin
                w_shamt      = {i_off & HALF_MASK, 3'b000};
                w_field_mask = INST_SZ'(16'hFFFF);
            end
            LD_WORD: begin
                // For a 32-bit datapath the masked offset is always 0: word == full.
                w_shamt      = {i_off & WORD_MASK, 3'b000};
                w_field_mask = INST_SZ'(32'hFFFF_FFFF);
            end
            LD_FULL: begin
                w_shamt      = {OFF_SZ + 3{1'b0}};
                w_field_mask = {INST_SZ{1'b1}};
            end
            default: begin
                w_shamt      = {OFF_SZ + 3{1'b0}};
                w_field_mask = {INST_SZ{1'b1}};
            end
        endcase
        w_shifted = i_data >> w_shamt;
        case (i_size)
            LD_BYTE: w_sign = w_shifted[7];
            LD_HALF: w_sign = w_shifted[15];
            LD_WORD: w_sign = w_shifted[31];
            LD_FULL: w_sign = w_shifted[INST_SZ-1];
            default: w_sign = 1'b0;
        endcase
    end

    // Keep the field bits and fill the rest with the extension bit.
    always_comb begin
        if (i_unsigned) begin
            o_data = w_shifted & w_field_mask;
        end else begin
            o_data = (w_shifted & w_field_mask) | ({INST_SZ{w_sign}} & ~w_field_mask);
        end
    end

endmodule

// File: rtl/wb_pipe.sv
// wb_pipe: registered write-back stage.
// Captures the MEM/WB pipeline register (flush > stall > load), aligns and
// extends load data, selects the register-file write value and counts
// retired instructions with a saturating counter.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset (release expected
//                         synchronous to i_clk)
//   i_stall, i_flush      hold W / load a bubble into W
//   i_*_M                 MEM-stage instruction fields
//   i_cnt_clear           synchronous retired-counter clear
//   o_write_data_W        register-file write data
//   o_write_reg_W         destination register
//   o_reg_write_W         write enable, suppressed for invalid or r0
//   o_valid_W             W holds a valid instruction
//   o_retired_count       instructions accepted into W (saturating)
// All outputs depend only on W-register state.
module wb_pipe
    import wb_pkg::*;
#(
    parameter int INST_SZ     = 32,
    parameter int REG_ADDR_SZ = 5,
    parameter int CNT_SZ      = 32
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic                   i_valid_M,
    input  logic [INST_SZ-1:0]     i_alu_result_M,
    input  logic [INST_SZ-1:0]     i_read_data_M,
    input  logic [INST_SZ-1:0]     i_branch_delay_slot_M,
    input  logic                   i_mem_to_reg_M,
    input  logic                   i_bds_sel_M,
    input  logic                   i_reg_write_M,
    input  logic [REG_ADDR_SZ-1:0] i_write_reg_M,
    input  logic [1:0]             i_load_size_M,
    input  logic                   i_load_unsigned_M,
    input  logic                   i_cnt_clear,
    output logic [INST_SZ-1:0]     o_write_data_W,
    output logic [REG_ADDR_SZ-1:0] o_write_reg_W,
    output logic                   o_reg_write_W,
    output logic                   o_valid_W,
    output logic [CNT_SZ-1:0]      o_retired_count
);

    localparam int OFF_SZ = $clog2(INST_SZ / 8);

    if (!inst_sz_ok(INST_SZ)) begin : g_bad_inst_sz
        $error("wb_pipe: INST_SZ must be 32 or 64");
    end

    logic                   r_valid;
    logic [INST_SZ-1:0]     r_alu_result;
    logic [INST_SZ-1:0]     r_read_data;
    logic [INST_SZ-1:0]     r_bds;
    logic                   r_mem_to_reg;
    logic                   r_bds_sel;
    logic                   r_reg_write;
    logic [REG_ADDR_SZ-1:0] r_write_reg;
    ld_size_e               r_load_size;
    logic                   r_load_unsigned;
    logic [CNT_SZ-1:0]      r_count;
    logic [INST_SZ-1:0]     w_load_data;
    logic                   w_accept;

    assign w_accept = ~i_flush & ~i_stall;

    // W register: flush inserts a bubble, stall holds, otherwise load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid         <= RST_VALID;
            r_alu_result    <= {INST_SZ{RST_DATA_BIT}};
            r_read_data     <= {INST_SZ{RST_DATA_BIT}};
            r_bds           <= {INST_SZ{RST_DATA_BIT}};
            r_mem_to_reg    <= RST_CTRL;
            r_bds_sel       <= RST_CTRL;
            r_reg_write     <= RST_CTRL;
            r_write_reg     <= {REG_ADDR_SZ{RST_DATA_BIT}};
            r_load_size     <= RST_LOAD_SIZE;
            r_load_unsigned <= RST_CTRL;
        end else if (i_flush) begin
            r_valid         <= RST_VALID;
            r_alu_result    <= {INST_SZ{RST_DATA_BIT}};
            r_read_data     <= {INST_SZ{RST_DATA_BIT}};
            r_bds           <= {INST_SZ{RST_DATA_BIT}};
            r_mem_to_reg    <= RST_CTRL;
            r_bds_sel       <= RST_CTRL;
            r_reg_write     <= RST_CTRL;
            r_write_reg     <= {REG_ADDR_SZ{RST_DATA_BIT}};
            r_load_size     <= RST_LOAD_SIZE;
            r_load_unsigned <= RST_CTRL;
        end else if (!i_stall) begin
            r_valid         <= i_valid_M;
            r_alu_result    <= i_alu_result_M;
            r_read_data     <= i_read_data_M;
            r_bds           <= i_branch_delay_slot_M;
            r_mem_to_reg    <= i_mem_to_reg_M;
            r_bds_sel       <= i_bds_sel_M;
            r_reg_write     <= i_reg_write_M;
            r_write_reg     <= i_write_reg_M;
            r_load_size     <= ld_size_e'(i_load_size_M);
            r_load_unsigned <= i_load_unsigned_M;
        end
    end

    // Retired counter: clear wins over increment; saturates at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= {CNT_SZ{1'b0}};
        end else if (i_cnt_clear) begin
            r_count <= {CNT_SZ{1'b0}};
        end else if (w_accept && i_valid_M && (r_count != {CNT_SZ{1'b1}})) begin
            r_count <= r_count + CNT_SZ'(1);
        end
    end

    wb_pipe_load_align #(
        .INST_SZ (INST_SZ),
        .OFF_SZ  (OFF_SZ)
    ) u_load_align (
        .i_data     (r_read_data),
        .i_off      (r_alu_result[OFF_SZ-1:0]),
        .i_size     (r_load_size),
        .i_unsigned (r_load_unsigned),
        .o_data     (w_load_data)
    );

    // Write-data select: return address overrides load data over ALU result.
    always_comb begin
        if (r_bds_sel) begin
            o_write_data_W = r_bds;
        end else if (r_mem_to_reg) begin
            o_write_data_W = w_load_data;
        end else begin
            o_write_data_W = r_alu_result;
        end
    end

    assign o_write_reg_W   = r_write_reg;
    assign o_reg_write_W   = r_reg_write & r_valid & (r_write_reg != {REG_ADDR_SZ{1'b0}});
    assign o_valid_W       = r_valid;
    assign o_retired_count = r_count;

endmodule

// File: tb/tb_wb_pipe.sv
// Self-checking bench for wb_pipe: 32-bit, 64-bit and 4-bit-counter builds.
module tb_wb_pipe;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, stall, flush, valid, m2r, bds_sel, rw, uns, clr;
    logic [31:0] alu, rdata, bds;
    logic [63:0] alu64, rdata64, bds64;
    logic [4:0]  wr;
    logic [1:0]  size;

    logic [31:0] d32;  logic [4:0] wr32; logic we32, v32; logic [31:0] c32;
    logic [63:0] d64;  logic [4:0] wr64; logic we64, v64; logic [31:0] c64;
    logic [31:0] dc4;  logic [4:0] wrc4; logic wec4, vc4; logic [3:0]  c4;

    int n_run = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    wb_pipe u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid_M(valid),
        .i_alu_result_M(alu), .i_read_data_M(rdata), .i_branch_delay_slot_M(bds),
        .i_mem_to_reg_M(m2r), .i_bds_sel_M(bds_sel), .i_reg_write_M(rw), .i_write_reg_M(wr),
        .i_load_size_M(size), .i_load_unsigned_M(uns), .i_cnt_clear(clr),
        .o_write_data_W(d32), .o_write_reg_W(wr32), .o_reg_write_W(we32), .o_valid_W(v32),
        .o_retired_count(c32));

    wb_pipe #(.INST_SZ(64)) u_dut64 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid_M(valid),
        .i_alu_result_M(alu64), .i_read_data_M(rdata64), .i_branch_delay_slot_M(bds64),
        .i_mem_to_reg_M(m2r), .i_bds_sel_M(bds_sel), .i_reg_write_M(rw), .i_write_reg_M(wr),
        .i_load_size_M(size), .i_load_unsigned_M(uns), .i_cnt_clear(clr),
        .o_write_data_W(d64), .o_write_reg_W(wr64), .o_reg_write_W(we64), .o_valid_W(v64),
        .o_retired_count(c64));

    wb_pipe #(.CNT_SZ(4)) u_dutc4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_stall(stall), .i_flush(flush), .i_valid_M(valid),
        .i_alu_result_M(alu), .i_read_data_M(rdata), .i_branch_delay_slot_M(bds),
        .i_mem_to_reg_M(m2r), .i_bds_sel_M(bds_sel), .i_reg_write_M(rw), .i_write_reg_M(wr),
        .i_load_size_M(size), .i_load_unsigned_M(uns), .i_cnt_clear(clr),
        .o_write_data_W(dc4), .o_write_reg_W(wrc4), .o_reg_write_W(wec4), .o_valid_W(vc4),
        .o_retired_count(c4));

    typedef struct {
        logic [31:0] alu, rdata, bds;
        logic        m2r, bds_sel, rw;
        logic [4:0]  wr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] rd, input logic [31:0] b,
                         input logic mr, input logic bs, input logic w, input logic [4:0] r,
                         input logic [1:0] sz, input logic u);
        valid = 1'b1; alu = a; rdata = rd; bds = b; m2r = mr; bds_sel = bs;
        rw = w; wr = r; size = sz; uns = u;
    endtask

    initial begin
        int exp_cnt;
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0; clr = 1'b0;
        drive(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 2'b00, 1'b0);
        valid = 1'b0;
        alu64 = 64'h0; rdata64 = 64'h0; bds64 = 64'h0;

        // Directed vectors: 32-bit alignment, extension, select and r0 suppression.
        vecs[0]  = '{32'h3, 32'h80FF_7F01, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, LD_BYTE, 1'b0, 32'hFFFF_FF80, 1'b1};
        vecs[1]  = '{32'h3, 32'h80FF_7F01, 32'h0, 1'b1, 1'b0, 1'b1, 5'd5, LD_BYTE, 1'b1, 32'h0000_0080, 1'b1};
        vecs[2]  = '{32'h1, 32'h1234_8765, 32'h0, 1'b1, 1'b0, 1'b1, 5'd6, LD_HALF, 1'b0, 32'hFFFF_8765, 1'b1};
        vecs[3]  = '{32'h0, 32'h1234_5678, 32'h0000_0408, 1'b1, 1'b1, 1'b1, 5'd31, LD_WORD, 1'b0, 32'h0000_0408, 1'b1};
        vecs[4]  = '{32'h55, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd0, LD_WORD, 1'b0, 32'h0000_0055, 1'b0};
        vecs[5]  = '{32'h0, 32'h80FF_7F01, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, LD_BYTE, 1'b1, 32'h0000_0001, 1'b1};
        vecs[6]  = '{32'h1, 32'h80FF_7F01, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, LD_BYTE, 1'b0, 32'h0000_007F, 1'b1};
        vecs[7]  = '{32'h2, 32'h80FF_7F01, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, LD_BYTE, 1'b0, 32'hFFFF_FFFF, 1'b1};
        vecs[8]  = '{32'h2, 32'h1234_8765, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, LD_HALF, 1'b1, 32'h0000_1234, 1'b1};
        vecs[9]  = '{32'h3, 32'h9ABC_0000, 32'h0, 1'b1, 1'b0, 1'b1, 5'd2, LD_HALF, 1'b0, 32'hFFFF_9ABC, 1'b1};
        vecs[10] = '{32'h1, 32'h8000_0001, 32'h0, 1'b1, 1'b0, 1'b1, 5'd9, LD_FULL, 1'b0, 32'h8000_0001, 1'b1};
        vecs[11] = '{32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd9, LD_BYTE, 1'b0, 32'hDEAD_BEEF, 1'b0};

        // Reset state (reset asserted before any edge).
        #12;
        chk("rst_data32", d32, 64'h0);
        chk("rst_valid32", v32, 64'h0);
        chk("rst_we32", we32, 64'h0);
        chk("rst_wr32", wr32, 64'h0);
        chk("rst_cnt32", c32, 64'h0);
        chk("rst_data64", d64, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Twenty valid loads: 4-bit counter saturates at 15.
        for (int i = 0; i < 20; i++) begin
            drive(32'(i), 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, LD_WORD, 1'b0);
            step();
        end
        chk("sat_cnt4", c4, 64'd15);
        chk("cnt32_20", c32, 64'd20);

        // Clear coincident with a valid load drops the increment.
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("clr_cnt32", c32, 64'd0);
        chk("clr_cnt4", c4, 64'd0);
        exp_cnt = 0;

        // Table-driven vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].alu, vecs[i].rdata, vecs[i].bds, vecs[i].m2r, vecs[i].bds_sel,
                  vecs[i].rw, vecs[i].wr, vecs[i].size, vecs[i].uns);
            step();
            exp_cnt++;
            chk($sformatf("vec%0d_data", i), d32, {32'h0, vecs[i].exp_data});
            chk($sformatf("vec%0d_we", i), we32, {63'h0, vecs[i].exp_we});
            chk($sformatf("vec%0d_valid", i), v32, 64'h1);
            chk($sformatf("vec%0d_wr", i), wr32, {59'h0, vecs[i].wr});
        end
        chk("cnt_after_table", c32, 64'(exp_cnt));

        // Stall: A held for four cycles, counted once.
        drive(32'h11, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd3, LD_WORD, 1'b0);
        step();
        exp_cnt++;
        chk("stallA_data0", d32, 64'h11);
        chk("stallA_cnt0", c32, 64'(exp_cnt));
        stall = 1'b1;
        drive(32'h22, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd4, LD_WORD, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            step();
            chk($sformatf("stallA_data%0d", k), d32, 64'h11);
            chk($sformatf("stallA_wr%0d", k), wr32, 64'd3);
            chk($sformatf("stallA_we%0d", k), we32, 64'h1);
            chk($sformatf("stallA_cnt%0d", k), c32, 64'(exp_cnt));
        end

        // Flush with stall high: bubble wins.
        flush = 1'b1;
        step();
        chk("flush_valid", v32, 64'h0);
        chk("flush_we", we32, 64'h0);
        chk("flush_data", d32, 64'h0);
        chk("flush_wr", wr32, 64'h0);
        chk("flush_cnt", c32, 64'(exp_cnt));
        stall = 1'b0;

        // Flush and clear together: both take effect.
        clr = 1'b1;
        step();
        flush = 1'b0; clr = 1'b0;
        chk("flushclr_valid", v32, 64'h0);
        chk("flushclr_cnt", c32, 64'h0);

        // 64-bit build alignment.
        rdata64 = 64'h8000_0001_0000_0002;
        drive(32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 5'd7, LD_WORD, 1'b0);
        alu64 = 64'h4;
        step();
        chk("w64_word_s", d64, 64'hFFFF_FFFF_8000_0001);
        alu64 = 64'h7; size = LD_BYTE;
        step();
        chk("w64_byte7_s", d64, 64'hFFFF_FFFF_FFFF_FF80);
        alu64 = 64'h6; size = LD_HALF; uns = 1'b1;
        step();
        chk("w64_half6_u", d64, 64'h0000_0000_0000_8000);
        alu64 = 64'h5; size = LD_FULL; uns = 1'b0;
        step();
        chk("w64_full", d64, 64'h8000_0001_0000_0002);

        // Reset asserted mid-stall clears outputs without a clock edge.
        drive(32'h33, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd8, LD_WORD, 1'b0);
        step();
        chk("pre_rst_data", d32, 64'h33);
        stall = 1'b1;
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_data", d32, 64'h0);
        chk("mid_rst_wr", wr32, 64'h0);
        chk("mid_rst_we", we32, 64'h0);
        chk("mid_rst_valid", v32, 64'h0);
        chk("mid_rst_cnt", c32, 64'h0);
        chk("mid_rst_cnt4", c4, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        stall = 1'b0;
        drive(32'h44, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 5'd10, LD_WORD, 1'b0);
        step();
        chk("post_rst_data", d32, 64'h44);
        chk("post_rst_cnt", c32, 64'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_pipe.md
# wb_pipe

Registered write-back stage for the pipelined CPU. It captures the MEM/WB pipeline register under stall and flush control, and aligns and sign- or zero-extends sub-word load data. It then selects the register-file write value from the ALU result, the load data or the branch-delay-slot return address, and keeps a saturating retired-instruction counter for the debug unit. It sits between the memory stage and the register file/forwarding unit, and replaces the purely combinational write-back mux pair.

## Interface
- INST_SZ, 32, datapath width; 32 or 64 only
- REG_ADDR_SZ, 5, register-file address width
- CNT_SZ, 32, retired-counter width
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_stall  in  1  hold W register contents
- i_flush  in  1  load a bubble into W
- i_valid_M  in  1  MEM-stage instruction valid
- i_alu_result_M  in  INST_SZ  ALU result; low bits are the load byte address
- i_read_data_M  in  INST_SZ  raw data-memory word
- i_branch_delay_slot_M  in  INST_SZ  link/return address
- i_mem_to_reg_M  in  1  select load data
- i_bds_sel_M  in  1  select return address (overrides mem_to_reg)
- i_reg_write_M  in  1  register write enable
- i_write_reg_M  in  REG_ADDR_SZ  destination register
- i_load_size_M  in  2  00 byte, 01 half, 10 word32, 11 full INST_SZ
- i_load_unsigned_M  in  1  zero-extend (1) / sign-extend (0)
- i_cnt_clear  in  1  synchronous retired-counter clear
- o_write_data_W  out  INST_SZ  register-file write data
- o_write_reg_W  out  REG_ADDR_SZ  destination register
- o_reg_write_W  out  1  qualified write enable
- o_valid_W  out  1  W holds a valid instruction
- o_retired_count  out  CNT_SZ  instructions accepted into W

## Operation
- **W register.** All `_M` inputs are captured into a W register on each edge. Priority is flush > stall > load.
  - Flush: valid, reg_write and all data/control fields are cleared to 0.
  - Stall: every field holds.
  - Otherwise: every field loads.
- **Load alignment.** Combinational from the registered values. OFF = alu_result[$clog2(INST_SZ/8)-1:0]. Little-endian: byte k occupies bits [8k+7:8k].
  - Byte: byte OFF.
  - Half: halfword OFF[..:1]; OFF[0] is ignored, so misaligned accesses are truncated.
  - Word32: word OFF[..:2]. For INST_SZ=32 this equals full.
  - Full: data passed through unchanged.
  - Extension: sign-extend from the top bit of the field unless load_unsigned is set.
- **Write-data select.** bds_sel → return address; else mem_to_reg → aligned load; else ALU result.
- **Write enable.** o_reg_write_W = reg_write & valid & (write_reg != 0). Writes to register 0 are suppressed.
- **Retired counter.** +1 on an edge where a load occurs (no flush, no stall) and i_valid_M=1.
  - Saturates at all-ones.
  - i_cnt_clear sets it to 0 and drops any coincident increment.
  - Stalled cycles never double-count.

## Timing
- Latency is 1 cycle: values presented before edge N appear on the W outputs after edge N. Outputs are combinational from the W register only, with no input→output combinational path.
- Reset (asynchronous assert on i_rst_n=0, synchronous release) sets every output to 0: write data 0, write reg 0, reg_write 0, valid 0, count 0.
- Reset asserted mid-stall discards the held instruction.
- Flush and stall in the same cycle: flush wins.
- Flush and clear in the same cycle: both apply.
- Stall for K cycles: outputs remain constant for K+1 cycles, and o_reg_write_W remains asserted throughout. The register file tolerates repeated identical writes.

## Structure
- Package wb_pkg holds:
  - load-size encodings: LD_BYTE, LD_HALF, LD_WORD, LD_FULL
  - W-register field reset values
  - an elaboration check that INST_SZ ∈ {32, 64}
- Sub-module: load_align, purely combinational (data, offset, size, unsigned → extended data). It is reused by a future misaligned-load exception unit.
- Top-level wb_pipe contains the W register, the select mux and the counter.

## Test plan
- **Sign-extended byte load.** Read data 0x80FF_7F01, offset 3, byte, signed, mem_to_reg=1 → write data 0xFFFF_FF80 one cycle later. With unsigned set → 0x0000_0080.
- **Half load, offset bit 0 ignored.** Read data 0x1234_8765, offset 1, half, signed → 0xFFFF_8765.
- **Select priority.** bds_sel=1 with mem_to_reg=1, return address 0x0000_0408 → write data 0x408.
- **Register-0 suppression.** write_reg=0, reg_write=1 → o_reg_write_W=0 while o_valid_W=1.
- **Stall then flush, with counter.**
  - Load A (ALU 0x11), stall 3 cycles while presenting B: W outputs show A for 4 cycles and the count rises by 1 only.
  - Flush with stall high: next cycle o_valid_W=0, o_reg_write_W=0, write data 0.
  - 64-bit build, word32 signed, offset 4, read data 0x8000_0001_0000_0002 → 0xFFFF_FFFF_8000_0001.
- **Counter saturation, clear and reset.**
  - CNT_SZ=4: 20 valid loads → count 15.
  - Clear coincident with a valid load → 0.
  - i_rst_n low mid-stall → all outputs 0 immediately, without waiting for a clock edge.
